// File: rtl/timer_input_sel.sv
// Registered N:1 selector for the TimerInput path with an ack/err select handshake and a settle blank.
// Optional build macro TIMER_INPUT_SEL_HOLD_LAST_EN: hold the last pass-through data during the blank.
module timer_input_sel #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SETTLE   = 2,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [CHANNELS-1:0]       valid_in,
    input  logic                      sel_req,
    input  logic [SEL_W-1:0]          sel_in,
    output logic                      sel_ack,
    output logic                      sel_err,
    output logic [SEL_W-1:0]          active_sel,
    output logic [WIDTH-1:0]          data_out,
    output logic                      valid_out
);

    typedef enum logic [0:0] {
        ST_PASS  = 1'b0,
        ST_BLANK = 1'b1
    } state_e;

    // One extra bit so CHANNELS itself is representable when it is a power of two.
    localparam logic [SEL_W:0] CH_LIM      = (SEL_W + 1)'(CHANNELS);
    localparam logic [3:0]     SETTLE_LOAD = 4'(SETTLE);

    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
        $error("timer_input_sel: SETTLE must be in 1..15");
    end
    if (CHANNELS < 2 || CHANNELS > 16) begin : g_bad_channels
        $error("timer_input_sel: CHANNELS must be in 2..16");
    end

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [SEL_W-1:0]  active_sel_q, active_sel_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              valid_q, valid_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [WIDTH-1:0]  sel_data_s;
    logic              sel_valid_s;
    logic              req_illegal_s;
    logic              req_same_s;

    // AND-OR mux of the currently active channel.
    always_comb begin
        sel_data_s  = {WIDTH{1'b0}};
        sel_valid_s = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            sel_data_s  = sel_data_s | (data_in[k*WIDTH +: WIDTH] & {WIDTH{active_sel_q == SEL_W'(k)}});
            sel_valid_s = sel_valid_s | (valid_in[k] & (active_sel_q == SEL_W'(k)));
        end
    end

    // Classify the incoming request against the channel range and the active channel.
    always_comb begin
        req_illegal_s = ({1'b0, sel_in} >= CH_LIM);
        req_same_s    = (sel_in == active_sel_q);
    end

    // Next-state, handshake pulses and output data.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        active_sel_d = active_sel_q;
        data_d       = data_q;
        valid_d      = valid_q;
        ack_d        = 1'b0;
        err_d        = 1'b0;
        case (state_q)
            ST_PASS: begin
                data_d  = sel_data_s;
                valid_d = sel_valid_s;
                if (sel_req) begin
                    if (req_illegal_s) begin
                        err_d = 1'b1;
                    end else if (req_same_s) begin
                        ack_d = 1'b1;
                    end else begin
                        ack_d        = 1'b1;
                        active_sel_d = sel_in;
                        cnt_d        = SETTLE_LOAD;
                        state_d      = ST_BLANK;
                    end
                end else begin
                    state_d = ST_PASS;
                end
            end
            ST_BLANK: begin
`ifdef TIMER_INPUT_SEL_HOLD_LAST_EN
                data_d  = data_q;
`else
                data_d  = {WIDTH{1'b0}};
`endif
                valid_d = 1'b0;
                cnt_d   = cnt_q - 4'd1;
                // Requests are deliberately dropped here; the requester re-issues in PASS.
                if (cnt_q <= 4'd1) begin
                    state_d = ST_PASS;
                end else begin
                    state_d = ST_BLANK;
                end
            end
            default: begin
                state_d      = ST_PASS;
                cnt_d        = 4'd0;
                active_sel_d = {SEL_W{1'b0}};
                data_d       = {WIDTH{1'b0}};
                valid_d      = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_PASS;
            cnt_q        <= 4'd0;
            active_sel_q <= {SEL_W{1'b0}};
            data_q       <= {WIDTH{1'b0}};
            valid_q      <= 1'b0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            active_sel_q <= active_sel_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
        end
    end

    assign sel_ack    = ack_q;
    assign sel_err    = err_q;
    assign active_sel = active_sel_q;
    assign data_out   = data_q;
    assign valid_out  = valid_q;

endmodule

// File: tb/tb_timer_input_sel.sv
// Directed bench for timer_input_sel (3 channels, SETTLE=2) with a gap-countdown reference model.
module tb_timer_input_sel;

    localparam int W  = 4;
    localparam int CH = 3;
    localparam int ST = 2;
    localparam int SW = 2;
`ifdef TIMER_INPUT_SEL_HOLD_LAST_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [CH*W-1:0]   data_in = '0;
    logic [CH-1:0]     valid_in = '0;
    logic              sel_req = 1'b0;
    logic [SW-1:0]     sel_in = '0;
    logic              sel_ack;
    logic              sel_err;
    logic [SW-1:0]     active_sel;
    logic [W-1:0]      data_out;
    logic              valid_out;

    int total = 0;
    int bad   = 0;
    bit done  = 1'b0;

    // Model: the active channel, how many blank cycles remain, and the expected outputs.
    logic [SW-1:0] m_active;
    int            m_left;
    logic [W-1:0]  m_data;
    logic          m_valid, m_ack, m_err;

    timer_input_sel #(.WIDTH(W), .CHANNELS(CH), .SETTLE(ST)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
        .sel_req(sel_req), .sel_in(sel_in), .sel_ack(sel_ack), .sel_err(sel_err),
        .active_sel(active_sel), .data_out(data_out), .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] chan(input logic [CH*W-1:0] d, input int k);
        return d[k*W +: W];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a request in pass-through mode opens a gap of ST blank cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= '0; m_left <= 0; m_data <= '0;
            m_valid  <= 1'b0; m_ack <= 1'b0; m_err <= 1'b0;
        end else if (m_left > 0) begin
            m_left  <= m_left - 1;
            m_valid <= 1'b0;
            m_data  <= HOLD ? m_data : '0;
            m_ack   <= 1'b0;
            m_err   <= 1'b0;
        end else begin
            m_data  <= chan(data_in, int'(m_active));
            m_valid <= valid_in[m_active];
            m_ack   <= sel_req && (int'(sel_in) < CH);
            m_err   <= sel_req && (int'(sel_in) >= CH);
            if (sel_req && int'(sel_in) < CH && sel_in != m_active) begin
                m_active <= sel_in;
                m_left   <= ST;
            end
        end
    end

    initial begin
        while (!done) begin
            @(negedge clk);
            chk("cmp_data",   32'(data_out),   32'(m_data));
            chk("cmp_valid",  32'(valid_out),  32'(m_valid));
            chk("cmp_active", 32'(active_sel), 32'(m_active));
            chk("cmp_ack",    32'(sel_ack),    32'(m_ack));
            chk("cmp_err",    32'(sel_err),    32'(m_err));
            chk("cmp_excl",   32'(sel_ack & sel_err), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        data_in  = {4'h9, 4'h3, 4'h7};
        valid_in = 3'b111;
        tick(); tick();
        chk("rst_data",   32'(data_out),   32'h0);
        chk("rst_valid",  32'(valid_out),  32'h0);
        chk("rst_active", 32'(active_sel), 32'h0);
        rst = 1'b0;
        tick();
        chk("pass_data",  32'(data_out),  32'h7);
        chk("pass_valid", 32'(valid_out), 32'h1);

        // Switch 0 -> 2 with a two-cycle blank.
        sel_req = 1'b1; sel_in = 2'd2;
        tick();
        chk("sw_ack",    32'(sel_ack),    32'h1);
        chk("sw_active", 32'(active_sel), 32'h2);
        chk("sw_valid0", 32'(valid_out),  32'h1);
        sel_req = 1'b0;
        tick();
        chk("sw_gap1", 32'(valid_out), 32'h0);
        chk("sw_ack1", 32'(sel_ack),   32'h0);
        tick();
        chk("sw_gap2", 32'(valid_out), 32'h0);
        tick();
        chk("sw_data", 32'(data_out),  32'h9);
        chk("sw_vld",  32'(valid_out), 32'h1);

        // Out-of-range select.
        sel_req = 1'b1; sel_in = 2'd3;
        tick();
        chk("ill_err",    32'(sel_err),    32'h1);
        chk("ill_ack",    32'(sel_ack),    32'h0);
        chk("ill_active", 32'(active_sel), 32'h2);
        chk("ill_data",   32'(data_out),   32'h9);
        sel_req = 1'b0;
        tick();
        chk("ill_err0",  32'(sel_err),   32'h0);
        chk("ill_noblk", 32'(valid_out), 32'h1);

        // Held same-channel request acks every cycle without a gap.
        sel_req = 1'b1; sel_in = 2'd2;
        tick();
        chk("same_ack1", 32'(sel_ack),   32'h1);
        chk("same_vld1", 32'(valid_out), 32'h1);
        tick();
        chk("same_ack2", 32'(sel_ack),   32'h1);
        chk("same_vld2", 32'(valid_out), 32'h1);
        sel_req = 1'b0;
        tick();

        // Only the active channel's valid matters.
        valid_in = 3'b110;
        tick();
        chk("vin_other", 32'(valid_out), 32'h1);
        valid_in = 3'b011;
        tick();
        chk("vin_sel", 32'(valid_out), 32'h0);
        valid_in = 3'b111;
        tick();

        // Request during the blank is ignored.
        sel_req = 1'b1; sel_in = 2'd1;
        tick();
        chk("mb_ack", 32'(sel_ack), 32'h1);
        sel_in = 2'd0;
        tick();
        chk("mb_ack1", 32'(sel_ack | sel_err), 32'h0);
        chk("mb_act1", 32'(active_sel), 32'h1);
        tick();
        chk("mb_ack2", 32'(sel_ack | sel_err), 32'h0);
        sel_req = 1'b0;
        tick();
        chk("mb_data",   32'(data_out),   32'h3);
        chk("mb_active", 32'(active_sel), 32'h1);

        // Held request to a new channel: ack, blank, then ack again as a same-channel request.
        sel_req = 1'b1; sel_in = 2'd0;
        tick();
        chk("held_ack1", 32'(sel_ack), 32'h1);
        tick(); tick();
        tick();
        chk("held_ack2", 32'(sel_ack),   32'h1);
        chk("held_vld",  32'(valid_out), 32'h1);
        sel_req = 1'b0;
        data_in = {4'h9, 4'h3, 4'h5};
        tick(); tick();
        chk("ch0_data", 32'(data_out), 32'h5);

        // Blank data content: zero by default, last value in the hold build.
        sel_req = 1'b1; sel_in = 2'd1;
        tick();
        sel_req = 1'b0;
        tick();
        chk("hl_data1", 32'(data_out),  HOLD ? 32'h5 : 32'h0);
        chk("hl_vld1",  32'(valid_out), 32'h0);
        tick();
        chk("hl_data2", 32'(data_out),  HOLD ? 32'h5 : 32'h0);
        tick();
        chk("hl_new",   32'(data_out),  32'h3);
        chk("hl_vld",   32'(valid_out), 32'h1);

        // Asynchronous reset while blanking.
        sel_req = 1'b1; sel_in = 2'd2;
        tick();
        sel_req = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("ar_active", 32'(active_sel), 32'h0);
        chk("ar_data",   32'(data_out),   32'h0);
        chk("ar_valid",  32'(valid_out),  32'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("ar_pass",  32'(data_out),   32'h5);
        chk("ar_vld",   32'(valid_out),  32'h1);
        chk("ar_act",   32'(active_sel), 32'h0);
        tick(); tick();
        done = 1'b1;
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
